// File: rtl/multi_voice_sound.sv
// Multi-voice square-wave tone sequencer with per-step decaying envelope, PWM-mixed to 1 bit.
// Latency: sound is registered, 1 cycle after x/state; busy/step update the cycle after a frame_tick.
// Backpressure: none; free-running on line/frame strobes, play=0 aborts to IDLE on the next clock.
module multi_voice_sound #(
  parameter int VOICES          = 2,
  parameter int STEPS           = 16,
  parameter int FRAMES_PER_STEP = 4,
  parameter int PERIOD_W        = 5,
  parameter int ENV_W           = 5,
  parameter int DECAY           = 8,
  parameter int X_BASE          = 128,
  localparam int STEP_W         = (STEPS > 1) ? $clog2(STEPS) : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            line_tick,
  input  logic                            frame_tick,
  input  logic [9:0]                      x,
  input  logic                            play,
  input  logic                            loop,
  input  logic [VOICES*STEPS*PERIOD_W-1:0] note_table,
  output logic                            sound,
  output logic                            busy,
  output logic [STEP_W-1:0]               step
);

  localparam int FC_W    = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam int ENV_MAX = (1 << ENV_W) - 1;
  localparam logic [FC_W-1:0]   FC_LAST   = FC_W'(FRAMES_PER_STEP - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEPS - 1);

  // Slots must fit in the 10-bit line and the widest window must fit in one 256-pixel slot.
  if (X_BASE + VOICES * 256 > 1024) begin : g_err_slots
    $error("multi_voice_sound: voice slots exceed 1024 pixels");
  end
  if ((ENV_MAX << 3) > 255) begin : g_err_env
    $error("multi_voice_sound: envelope window wider than a slot");
  end

  typedef enum logic {IDLE, PLAY} state_t;

  state_t              state;
  logic [FC_W-1:0]     fcnt;
  logic [PERIOD_W-1:0] cnt    [VOICES];
  logic [ENV_W-1:0]    env    [VOICES];
  logic [VOICES-1:0]   phase;
  logic [PERIOD_W-1:0] period [VOICES];
  logic [VOICES-1:0]   on;

  // Half-period of each voice at the current step.
  always_comb begin
    for (int v = 0; v < VOICES; v++) begin
      period[v] = note_table[(int'(step) * VOICES + v) * PERIOD_W +: PERIOD_W];
    end
  end

  // Pulse-width window of each voice inside its own slot; 11-bit compare so the end never wraps.
  always_comb begin
    on = '0;
    for (int v = 0; v < VOICES; v++) begin
      on[v] = phase[v]
            && ({1'b0, x} >= 11'(X_BASE + v * 256))
            && ({1'b0, x} <  11'(X_BASE + v * 256) + 11'({env[v], 3'b000}));
    end
  end

  // Sequencer FSM: step/frame counting, envelopes, per-voice tone counters and the mixed output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      step  <= '0;
      fcnt  <= '0;
      phase <= '0;
      sound <= 1'b0;
      for (int v = 0; v < VOICES; v++) begin
        cnt[v] <= '0;
        env[v] <= '0;
      end
    end else begin
      sound <= (state == PLAY) && (|on);
      case (state)
        IDLE: begin
          busy  <= 1'b0;
          step  <= '0;
          fcnt  <= '0;
          phase <= '0;
          for (int v = 0; v < VOICES; v++) begin
            cnt[v] <= '0;
            env[v] <= '0;
          end
          if (frame_tick && play) begin
            state <= PLAY;
            busy  <= 1'b1;
            for (int v = 0; v < VOICES; v++) env[v] <= ENV_W'(ENV_MAX);
          end
        end
        PLAY: begin
          if (!play) begin
            state <= IDLE;
            busy  <= 1'b0;
            step  <= '0;
            fcnt  <= '0;
            phase <= '0;
            for (int v = 0; v < VOICES; v++) begin
              cnt[v] <= '0;
              env[v] <= '0;
            end
          end else if (frame_tick && (fcnt == FC_LAST)) begin
            // Step end: clears take priority over a coincident line tick.
            fcnt  <= '0;
            phase <= '0;
            for (int v = 0; v < VOICES; v++) cnt[v] <= '0;
            if (step != STEP_LAST || loop) begin
              step <= (step == STEP_LAST) ? '0 : step + 1'b1;
              for (int v = 0; v < VOICES; v++) env[v] <= ENV_W'(ENV_MAX);
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              step  <= '0;
              for (int v = 0; v < VOICES; v++) env[v] <= '0;
            end
          end else begin
            if (frame_tick) begin
              fcnt <= fcnt + 1'b1;
              for (int v = 0; v < VOICES; v++) begin
                env[v] <= (int'(env[v]) > DECAY) ? env[v] - ENV_W'(DECAY) : '0;
              end
            end
            if (line_tick) begin
              for (int v = 0; v < VOICES; v++) begin
                if (period[v] == '0) begin
                  cnt[v]   <= '0;
                  phase[v] <= 1'b0;
                end else if (cnt[v] >= period[v]) begin
                  cnt[v]   <= '0;
                  phase[v] <= ~phase[v];
                end else begin
                  cnt[v] <= cnt[v] + 1'b1;
                end
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_voice_sound.sv
// Directed bench for multi_voice_sound: tone period, envelope windows, sequencing, loop/stop, reset.
// Inputs change on the falling edge; outputs are sampled on the falling edge after the sampling edge.
// Strobes are driven as isolated pulses so each scenario stays short.
module tb_multi_voice_sound;

  localparam int VOICES = 2;
  localparam int STEPS  = 16;
  localparam int PW     = 5;

  logic                        clk = 1'b0;
  logic                        rst_n = 1'b0;
  logic                        line_tick = 1'b0;
  logic                        frame_tick = 1'b0;
  logic [9:0]                  x = '0;
  logic                        play = 1'b0;
  logic                        loop = 1'b0;
  logic [VOICES*STEPS*PW-1:0]  note_table;
  logic                        sound;
  logic                        busy;
  logic [3:0]                  step;

  int n_checks = 0;
  int n_errors = 0;

  multi_voice_sound dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .line_tick  (line_tick),
    .frame_tick (frame_tick),
    .x          (x),
    .play       (play),
    .loop       (loop),
    .note_table (note_table),
    .sound      (sound),
    .busy       (busy),
    .step       (step)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic pulse_frame();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
  endtask

  task automatic pulse_line();
    @(negedge clk) line_tick = 1'b1;
    @(negedge clk) line_tick = 1'b0;
  endtask

  // Line tick, then one more clock so the registered sound shows the new phase at x=128.
  task automatic line_and_sample(input string tag, input logic exp_phase);
    pulse_line();
    @(negedge clk);
    chk(tag, sound, exp_phase);
  endtask

  // Sweep x across voice 0's slot; sound must equal the window of the x from one cycle earlier.
  task automatic sweep(input int w);
    @(negedge clk) x = 10'd124;
    for (int xi = 125; xi <= 381; xi++) begin
      @(negedge clk);
      chk("env_window", sound, ((xi - 1) >= 128 && (xi - 1) < 128 + w) ? 1 : 0);
      x = 10'(xi);
    end
    @(negedge clk) x = 10'd128;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int s = 0; s < STEPS; s++) begin
      for (int v = 0; v < VOICES; v++) begin
        note_table[((s * VOICES) + v) * PW +: PW] = (v == 0) ? 5'd3 : 5'd0;
      end
    end

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_sound", sound, 0);
    chk("rst_busy", busy, 0);
    chk("rst_step", step, 0);
    rst_n = 1'b1;

    // Start: first frame tick with play=1.
    play = 1'b1;
    loop = 1'b1;
    x    = 10'd128;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    pulse_frame();
    chk("start_busy", busy, 1);
    chk("start_step", step, 0);

    // Period 3 -> phase toggles every 4 line ticks.
    for (int n = 1; n <= 12; n++) begin
      line_and_sample("tone_phase", logic'((n / 4) % 2));
    end

    // Voice 1 (rest) slot stays silent while voice 0 phase is high.
    @(negedge clk) x = 10'd384;
    @(negedge clk);
    @(negedge clk);
    chk("voice1_silent", sound, 0);
    x = 10'd128;

    // Envelope windows across the four frames of step 0.
    sweep(248);
    pulse_frame();
    sweep(184);
    pulse_frame();
    sweep(120);
    pulse_frame();
    sweep(56);
    chk("frame3_step", step, 0);

    // Coincident line tick and step-end frame tick.
    pulse_line();
    @(negedge clk) begin line_tick = 1'b1; frame_tick = 1'b1; end
    @(negedge clk) begin line_tick = 1'b0; frame_tick = 1'b0; end
    chk("coinc_step", step, 1);
    @(negedge clk);
    chk("coinc_phase", sound, 0);
    line_and_sample("coinc_cnt1", 0);
    line_and_sample("coinc_cnt2", 0);
    line_and_sample("coinc_cnt3", 0);
    line_and_sample("coinc_cnt4", 1);
    @(negedge clk) x = 10'd375;
    @(negedge clk);
    chk("coinc_env_in", sound, 1);
    x = 10'd376;
    @(negedge clk);
    chk("coinc_env_out", sound, 0);
    x = 10'd128;

    // Stop, then non-loop sequencing over 16 steps x 4 frames.
    @(negedge clk) play = 1'b0;
    @(negedge clk);
    chk("stop_busy", busy, 0);
    chk("stop_step", step, 0);
    loop = 1'b0;
    play = 1'b1;
    pulse_frame();
    chk("seq_busy", busy, 1);
    for (int f = 1; f <= 64; f++) begin
      chk("seq_step", step, (f - 1) / 4);
      if (f < 64) chk("seq_busy_hold", busy, 1);
      pulse_frame();
    end
    chk("seq_end_busy", busy, 0);
    chk("seq_end_step", step, 0);
    for (int n = 0; n < 5; n++) begin
      line_and_sample("seq_end_sound", 0);
    end

    // Loop wrap, then drop play during step 5.
    play = 1'b0;
    @(negedge clk);
    loop = 1'b1;
    play = 1'b1;
    pulse_frame();
    for (int f = 0; f < 64; f++) pulse_frame();
    chk("loop_wrap_step", step, 0);
    chk("loop_wrap_busy", busy, 1);
    for (int f = 0; f < 20; f++) pulse_frame();
    chk("loop_step5", step, 5);
    @(negedge clk) play = 1'b0;
    @(negedge clk);
    chk("loop_stop_busy", busy, 0);
    chk("loop_stop_step", step, 0);

    // Reset asserted mid-PLAY with sound high.
    play = 1'b1;
    pulse_frame();
    for (int f = 0; f < 4; f++) pulse_frame();
    chk("pre_rst_step", step, 1);
    for (int n = 1; n <= 4; n++) line_and_sample("pre_rst_phase", logic'(n / 4));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sound", sound, 0);
    chk("arst_busy", busy, 0);
    chk("arst_step", step, 0);
    @(negedge clk) rst_n = 1'b1;
    for (int n = 0; n < 6; n++) line_and_sample("post_rst_quiet", 0);
    chk("post_rst_busy", busy, 0);
    pulse_frame();
    chk("restart_busy", busy, 1);
    for (int n = 1; n <= 4; n++) line_and_sample("restart_phase", logic'(n / 4));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multi_voice_sound.md
# multi_voice_sound

Parametrised multi-voice tone sequencer for the VGA-timed audio path. It plays a step table of per-voice square-wave half-periods, counted in scanlines, with a per-step decaying envelope. Each voice's envelope is rendered as a pulse-width window in its own horizontal slot of the scanline, and the windows are mixed onto a single 1-bit `sound` output. It sits beside the video timing generator and takes its line and frame strobes.

## Interface
- `VOICES`, 2: number of simultaneous voices.
- `STEPS`, 16: number of steps in the note table.
- `FRAMES_PER_STEP`, 4: frames each step lasts (≥1).
- `PERIOD_W`, 5: width of a half-period table entry.
- `ENV_W`, 5: envelope width; max envelope `ENV_MAX = 2^ENV_W-1`.
- `DECAY`, 8: envelope decrement per frame, saturating at 0.
- `X_BASE`, 128: first pixel of voice 0's slot. Slot width is 256.
  - Elaboration error if `X_BASE + VOICES*256 > 1024`.
  - Elaboration error if `ENV_MAX<<3 > 255`.

Ports:
- `clk`, in, 1: pixel clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `line_tick`, in, 1: one-cycle pulse per scanline, at x==0.
- `frame_tick`, in, 1: one-cycle pulse per frame.
- `x`, in, 10: current pixel column.
- `play`, in, 1: level. 1 requests playback.
- `loop`, in, 1: level. Sampled at the last step.
- `note_table`, in, `VOICES*STEPS*PERIOD_W`: half-period for voice v at step s.
  - Located at bits `[((s*VOICES)+v)*PERIOD_W +: PERIOD_W]`.
  - Value 0 means rest.
  - Must be stable while `busy`.
- `sound`, out, 1: registered mixed PWM output.
- `busy`, out, 1: high in PLAY.
- `step`, out, `$clog2(STEPS)`: current step index.

## Operation
- States: IDLE, PLAY.
- IDLE:
  - `step=0`, frame count 0, all voice counters and phases 0, envelopes 0.
  - On `frame_tick && play`: go to PLAY. Load every envelope with `ENV_MAX`. `step=0`.
- PLAY, on `frame_tick`:
  - If frame count < `FRAMES_PER_STEP-1`: frame count +1, and every envelope decrements by `DECAY` (saturating at 0).
  - Otherwise (step end): frame count goes to 0.
    - If `step < STEPS-1`: `step+1`.
    - If `step == STEPS-1` and `loop=1`: `step=0`.
    - If `step == STEPS-1` and `loop=0`: go to IDLE.
    - When staying in PLAY: envelopes reload to `ENV_MAX`, and all voice counters and phases clear to 0.
- PLAY, `play=0`: go to IDLE on the next clock, regardless of ticks. All IDLE clears apply.
- Tone, per voice, on `line_tick` in PLAY with period P = the table entry for (v, `step`):
  - P==0: counter and phase held at 0.
  - Else, if counter ≥ P: counter goes to 0 and phase toggles.
  - Else: counter +1.
  - Result: half-period is P+1 lines.
  - Counter width is `PERIOD_W`.
- Simultaneous `line_tick` and step-end `frame_tick`: the step-end clear wins. The line tick is not counted.
- Window, per voice v:
  - `on_v = phase_v && x >= X_BASE+v*256 && x < X_BASE+v*256+(env_v<<3)`.
  - Compare at 11-bit width, no wrap.
  - env 0 gives an empty window.
- Mix: `sound <= |on_v` (slots are disjoint). In IDLE, `sound <= 0`.
- Reset (async, any state): state IDLE, `sound=0`, `busy=0`, `step=0`, all internal registers 0.

## Timing
- `sound` follows `x` and the state with 1 cycle of latency.
- `busy` and `step` are registered. They change on the cycle after the qualifying `frame_tick`.
- Start latency: playback starts at the first `frame_tick` with `play=1`.
  - The first envelope window is `ENV_MAX<<3` pixels wide.
  - The first phase toggle occurs P+1 line ticks later.
- Steady PLAY, step length: exactly `FRAMES_PER_STEP` frame ticks.
- With defaults, envelope per frame of a step: 31, 23, 15, 7.
  - Window widths: 248, 184, 120, 56 pixels.
- Non-loop end: IDLE is entered on the step-end tick of step `STEPS-1`. `sound` is 0 from the next cycle.
- Reset asserted mid-PLAY: outputs clear immediately, asynchronously. Playback restarts only via `play` at a later `frame_tick`.

## Test plan
- Reset:
  - Stimulus: assert `rst_n=0` mid-PLAY.
  - Response: `sound`, `busy`, `step` all 0 asynchronously. No toggling until a new `play` and `frame_tick`.
- Tone period:
  - Stimulus: voice 0 table all 3, voice 1 all 0, defaults, `play=1`, `loop=1`.
  - Response: voice 0 phase toggles every 4 `line_tick`s. Voice 1 window never asserts.
- Envelope:
  - Stimulus: sample `sound` across one line while voice 0 phase=1, frames 0–3 of a step.
  - Response: high for x=128..375, then 128..311, then 128..247, then 128..183. Always 1-cycle delayed.
- Step sequencing:
  - Stimulus: `loop=0`, 16 steps × 4 frames.
  - Response: `step` counts 0..15, with each step lasting exactly 4 `frame_tick`s. `busy` falls after the 64th frame tick. `sound` stays 0 afterwards.
- Loop and stop:
  - Stimulus: `loop=1`, then drop `play` during step 5.
  - Response: `step` wraps from 15 to 0. After `play=0`, `busy=0` and `step=0` on the next clock.
- Coincident ticks:
  - Stimulus: `line_tick` and a step-end `frame_tick` in the same cycle.
  - Response: counter and phase are 0 afterwards. Envelope = 31.
